// File: rtl/pdm_pkg.sv
// Shared defaults, midscale constant and FSM state type for the PDM modulator.
package pdm_pkg;

   localparam int IN_W_DEF   = 16;
   localparam int RATE_W_DEF = 16;

   localparam logic [IN_W_DEF-1:0] MIDSCALE = {1'b1, {(IN_W_DEF-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pdm_state_t;

endpackage

// File: rtl/pdm_sd_core.sv
// First-order sigma-delta step: accumulate the offset-binary sample and emit the carry
// as the PDM bit on each tick.
module pdm_sd_core
   import pdm_pkg::*;
#(
   parameter int IN_W = IN_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_tick,
   input  logic            i_clr,
   input  logic [IN_W-1:0] i_cur,
   output logic            o_dout
);

   logic [IN_W-1:0] r_acc;
   logic            r_dout;
   logic [IN_W:0]   w_sum;

   // Widened sum so the carry-out is the output bit
   always_comb begin
      w_sum = {1'b0, r_acc} + {1'b0, i_cur};
   end

   // Accumulator and output bit; a clear drops the residue but keeps the last bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc  <= {IN_W{1'b0}};
         r_dout <= 1'b0;
      end else if (i_clr) begin
         r_acc  <= {IN_W{1'b0}};
         r_dout <= r_dout;
      end else if (i_tick) begin
         r_acc  <= w_sum[IN_W-1:0];
         r_dout <= w_sum[IN_W];
      end else begin
         r_acc  <= r_acc;
         r_dout <= r_dout;
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM modulator: 2-deep sample buffer, bit-period divider, OSR counter, run FSM.
// Build option PDM_UNDERRUN_MUTE_EN forces midscale into the modulator on underrun.
module pdm_modulator
   import pdm_pkg::*;
#(
   parameter int IN_W   = IN_W_DEF,
   parameter int RATE_W = RATE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RATE_W-1:0] rate,
   input  logic [RATE_W-1:0] osr,
   input  logic              rate_we,
   output logic              dout,
   output logic              dout_vld,
   output logic              underrun
);

   localparam logic [RATE_W-1:0] L_ZERO = {RATE_W{1'b0}};
   localparam logic [RATE_W-1:0] L_ONE  = {{(RATE_W-1){1'b0}}, 1'b1};
   localparam logic [IN_W-1:0]   L_MID  = {1'b1, {(IN_W-1){1'b0}}};

   pdm_state_t        r_state, w_state_next;
   logic [RATE_W-1:0] r_rate_q, r_osr_q, r_div_cnt, r_osr_cnt;
   logic [IN_W-1:0]   r_cur, r_nxt, w_nxt_u;
   logic              r_nxt_full, r_in_ready, r_dout_vld, r_underrun;
   logic              w_accept, w_cfg_zero, w_start, w_tick, w_boundary, w_take, w_nxt_full_next;

   // Handshake, tick and transfer decode; a config write pre-empts any tick that cycle
   always_comb begin
      w_nxt_u    = {~r_nxt[IN_W-1], r_nxt[IN_W-2:0]};
      w_accept   = in_valid && r_in_ready;
      w_cfg_zero = rate_we && ((rate == L_ZERO) || (osr == L_ZERO));
      w_start    = (r_state == ST_IDLE) && !rate_we && (r_rate_q != L_ZERO) &&
                   (r_osr_q != L_ZERO) && r_nxt_full;
      w_tick     = (r_state == ST_RUN) && !rate_we && clk_en && (r_div_cnt == r_rate_q - L_ONE);
      w_boundary = w_tick && (r_osr_cnt == r_osr_q - L_ONE);
      w_take     = w_start || (w_boundary && r_nxt_full);
      if (w_accept) begin
         w_nxt_full_next = 1'b1;
      end else if (w_take) begin
         w_nxt_full_next = 1'b0;
      end else begin
         w_nxt_full_next = r_nxt_full;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_cfg_zero) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Rate/OSR configuration and the divider/OSR counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rate_q  <= L_ZERO;
         r_osr_q   <= L_ZERO;
         r_div_cnt <= L_ZERO;
         r_osr_cnt <= L_ZERO;
      end else if (rate_we) begin
         r_rate_q  <= rate;
         r_osr_q   <= osr;
         r_div_cnt <= L_ZERO;
         r_osr_cnt <= L_ZERO;
      end else if (w_start) begin
         r_div_cnt <= L_ZERO;
         r_osr_cnt <= L_ZERO;
      end else if (w_tick) begin
         r_div_cnt <= L_ZERO;
         r_osr_cnt <= w_boundary ? L_ZERO : (r_osr_cnt + L_ONE);
      end else if ((r_state == ST_RUN) && clk_en) begin
         r_div_cnt <= r_div_cnt + L_ONE;
      end else begin
         r_div_cnt <= r_div_cnt;
         r_osr_cnt <= r_osr_cnt;
      end
   end

   // Sample buffer, current sample, and the registered handshake/status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_nxt      <= {IN_W{1'b0}};
         r_nxt_full <= 1'b0;
         r_cur      <= {IN_W{1'b0}};
         r_in_ready <= 1'b1;
         r_dout_vld <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_nxt      <= w_accept ? in_data : r_nxt;
         r_nxt_full <= w_nxt_full_next;
         r_in_ready <= !w_nxt_full_next;
         r_dout_vld <= w_tick;
         if (w_take) begin
            r_cur      <= w_nxt_u;
            r_underrun <= r_underrun;
         end else if (w_boundary) begin
`ifdef PDM_UNDERRUN_MUTE_EN
            r_cur      <= L_MID;
`else
            r_cur      <= r_cur;
`endif
            r_underrun <= 1'b1;
         end else begin
            r_cur      <= r_cur;
            r_underrun <= r_underrun;
         end
      end
   end

   pdm_sd_core #(.IN_W(IN_W)) u_core (
      .clk    (clk),
      .rst    (rst),
      .i_tick (w_tick),
      .i_clr  (w_cfg_zero),
      .i_cur  (r_cur),
      .o_dout (dout)
   );

   assign in_ready = r_in_ready;
   assign dout_vld = r_dout_vld;
   assign underrun = r_underrun;

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- First-order sigma-delta modulator that converts signed PCM samples into a 1-bit PDM stream.
- Transmit-side counterpart of the CIC decimator: its `dout`/`dout_vld` pair drives the decimator's `din`/`new_data` directly.
- Samples enter through a valid/ready handshake and are buffered in a 2-deep holding stage.
- Each sample is held for OSR output bits; bit pacing is set by a programmable divider on `clk_en`.

Parameters:
- IN_W, 16, PCM sample width (two's complement).
- RATE_W, 16, width of the bit-period divider and OSR registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global clock enable; divider and modulator advance only when high.
- in_data  in  IN_W  signed PCM sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready at a clk edge.
- rate  in  RATE_W  bit period, in enabled clk cycles.
- osr  in  RATE_W  output bits per input sample.
- rate_we  in  1  latches rate and osr.
- dout  out  1  PDM bit.
- dout_vld  out  1  one-cycle strobe per new bit; same contract as the decimator's new_data.
- underrun  out  1  sticky: OSR boundary reached with no pending sample.

Behaviour:
- Reset (rst=0, asynchronous): rate_q=0, osr_q=0, acc=0, cur=0, nxt empty, FSM=IDLE.
- Output reset values: dout=0, dout_vld=0, in_ready=1, underrun=0.
- Config: rate_we=1 loads rate_q/osr_q.
  - Divider count and OSR count restart at 0; acc is kept.
  - If either new value is 0: FSM->IDLE, acc cleared, nxt retained.
- Input buffer: in_ready = !nxt_full, registered.
  - Accept writes nxt; in_ready falls the next cycle.
  - Simultaneous accept and nxt->cur transfer is legal; nxt stays full with the new sample.
- Offset conversion: u = in_data with MSB inverted (unsigned, 0..2^IN_W-1).
- FSM:
  - IDLE: dout_vld=0. When rate_q!=0, osr_q!=0 and nxt full: cur<=u(nxt), nxt emptied, div_cnt=0, osr_cnt=0, ->RUN.
  - RUN: on clk_en, div_cnt increments. Tick when div_cnt==rate_q-1 and clk_en; div_cnt then wraps to 0.
- On tick:
  - sum = {1'b0,acc} + cur, IN_W+1 bits.
  - dout <= sum[IN_W]; acc <= sum[IN_W-1:0]; dout_vld <= 1 the next cycle only.
  - osr_cnt increments.
- OSR boundary, on the tick where osr_cnt==osr_q-1:
  - osr_cnt wraps to 0.
  - If nxt full: cur<=u(nxt), nxt emptied; the new cur is used from the following tick.
  - Else: underrun<=1 and cur is held.
- First dout_vld comes rate_q enabled cycles after entering RUN, plus 1 cycle.
- clk_en=0 freezes all counters and acc. dout_vld still deasserts after its single cycle.
- dout holds its last value between strobes.
- underrun clears only on reset.
- rate_q=1 gives a bit on every enabled cycle.
- Mid-operation reset: everything returns to reset values immediately; any pending sample is lost.

Optional Feature:
- PDM_UNDERRUN_MUTE_EN defined: on underrun, cur<=2^(IN_W-1) (midscale, i.e. PCM 0), giving a 50% density idle pattern.
- Undefined: cur holds the last sample.
- underrun flag behaviour is identical in both builds.

Decomposition:
- Package pdm_pkg holds:
  - IN_W/RATE_W defaults,
  - the MIDSCALE constant (1<<(IN_W-1)),
  - the FSM state enumeration (IDLE, RUN).
- Sub-module pdm_sd_core: the accumulator and carry-out step only (cur, tick in; dout, acc state).
- FSM, divider, OSR counter and buffer stay in the top level.

Test Plan:
- Reset, then rate=2, osr=4, rate_we pulse, push in_data=0, clk_en=1 -> dout_vld every 2nd cycle; dout sequence 0,1,0,1,...; underrun=1 after 4 bits.
- in_data=-32768 then 32767, rate=1, osr=8 -> 8 zeros; then 0 followed by ones (the first bit of the new sample is 0 because acc was 0); underrun rises at bit 16.
- Back-to-back pushes with in_valid held high -> in_ready drops after the first accept; each later accept lines up with an OSR boundary; no sample lost or duplicated; underrun stays 0.
- clk_en toggled 1,0,1,0 with rate=2 -> bit strobes spaced 4 clk cycles; dout pattern identical to the clk_en=1 run.
- rate_we with rate=0 mid-run -> no further dout_vld, FSM IDLE, acc=0. Rewrite rate=2 -> restart with first bit 0 for in_data=0.
- Async rst pulse mid-bit -> all outputs at reset values in the same cycle. With PDM_UNDERRUN_MUTE_EN, an underrun after a 32767 sample gives the 0,1 alternating pattern.
